// File: rtl/inv_seq_pkg.sv
// Shared types and constants for the inverter stimulus sequencer/checker.
package inv_seq_pkg;

  localparam int CNT_W_DEF = 16;
  localparam int ERR_W_DEF = 8;

  localparam logic DRV_A_RST = 1'b0;
  localparam logic DRV_B_RST = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/toggle_gen.sv
// Square-wave generator: q toggles every `period` enabled cycles; clr rearms
// the counter and restores the reset level.
module toggle_gen #(
  parameter int   CNT_W   = 16,
  parameter logic RST_VAL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] period,
  output logic             q
);

  logic [CNT_W-1:0] cnt;

  // period is nonzero here; the top level maps 0 to 1 when latching
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
      q   <= RST_VAL;
    end else if (en) begin
      if (cnt == period - CNT_W'(1)) begin
        cnt <= '0;
        q   <= ~q;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/inv_seq_ctrl.sv
// Two-channel inverter sequencer: drives a/b square waves for a run and counts
// cycles where y/z are not the complements of the driven inputs.
module inv_seq_ctrl
  import inv_seq_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int RUN_LEN = 1000,
  parameter int ERR_W   = ERR_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] period_a,
  input  logic [CNT_W-1:0] period_b,
  output logic             drv_a,
  output logic             drv_b,
  input  logic             obs_y,
  input  logic             obs_z,
  output logic             busy,
  output logic             done,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int NUM_CH = 2;

  state_e state, state_nxt;

  logic [NUM_CH-1:0][CNT_W-1:0] period_l;
  logic [NUM_CH-1:0]            drv;
  logic [CNT_W-1:0]             run_cnt;
  logic                         start_seq;
  logic                         run_last;
  logic                         mismatch;

  assign start_seq = (state == IDLE) && start;
  assign run_last  = (run_cnt == CNT_W'(RUN_LEN - 1));
  assign mismatch  = (obs_y == drv_a) || (obs_z == drv_b);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (stop || run_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // a zero half-period would never toggle; run it as 1 instead
  always_ff @(posedge clk) begin
    if (rst) begin
      period_l <= '0;
    end else if (start_seq) begin
      period_l[0] <= (period_a == '0) ? CNT_W'(1) : period_a;
      period_l[1] <= (period_b == '0) ? CNT_W'(1) : period_b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || start_seq)   run_cnt <= '0;
    else if (state == RUN)  run_cnt <= run_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst || start_seq) begin
      err_cnt <= '0;
    end else if ((state == RUN) && mismatch && (err_cnt != {ERR_W{1'b1}})) begin
      err_cnt <= err_cnt + ERR_W'(1);
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    toggle_gen #(
      .CNT_W  (CNT_W),
      .RST_VAL((i == 0) ? DRV_A_RST : DRV_B_RST)
    ) u_tg (
      .clk   (clk),
      .rst   (rst),
      .clr   (start_seq),
      .en    (state == RUN),
      .period(period_l[i]),
      .q     (drv[i])
    );
  end

  assign drv_a = drv[0];
  assign drv_b = drv[1];
  assign busy  = (state == RUN);
  assign done  = (state == DONE);

endmodule

// File: tb/tb_inv_seq_ctrl.sv
// Randomized bench for inv_seq_ctrl with an arithmetic reference model of the
// run index, expected waveforms and saturating error count.
module tb_inv_seq_ctrl;

  localparam int CNT_W   = 16;
  localparam int RUN_LEN = 1000;
  localparam int ERR_W   = 8;
  localparam int ERR_MAX = 255;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic [CNT_W-1:0] period_a = '0;
  logic [CNT_W-1:0] period_b = '0;
  logic             drv_a, drv_b, obs_y, obs_z, busy, done;
  logic [ERR_W-1:0] err_cnt;

  // inverter model with fault knobs
  logic tie_y = 1'b0, flip_y = 1'b0, flip_z = 1'b0;
  assign obs_y = tie_y ? drv_a : (~drv_a ^ flip_y);
  assign obs_z = ~drv_b ^ flip_z;

  inv_seq_ctrl #(.CNT_W(CNT_W), .RUN_LEN(RUN_LEN), .ERR_W(ERR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .period_a(period_a), .period_b(period_b),
    .drv_a(drv_a), .drv_b(drv_b), .obs_y(obs_y), .obs_z(obs_z),
    .busy(busy), .done(done), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  // model: m_idx = RUN cycles elapsed in the current/last sequence
  bit m_busy = 0, m_done = 0;
  int m_idx = 0, m_err = 0, m_pa = 1, m_pb = 1;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_edge();
    bit mis;
    mis = tie_y | flip_y | flip_z;
    if (rst) begin
      m_busy = 0; m_done = 0; m_err = 0; m_idx = 0;
    end else if (m_busy) begin
      if (mis && m_err < ERR_MAX) m_err++;
      m_idx++;
      if (stop || m_idx == RUN_LEN) begin
        m_busy = 0; m_done = 1;
      end
    end else if (m_done) begin
      m_done = 0;
    end else if (start) begin
      m_busy = 1; m_idx = 0; m_err = 0;
      m_pa = (period_a == 0) ? 1 : int'(period_a);
      m_pb = (period_b == 0) ? 1 : int'(period_b);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge();
      #1;
      chk("busy",  int'(busy),  int'(m_busy));
      chk("done",  int'(done),  int'(m_done));
      chk("drv_a", int'(drv_a), (m_idx / m_pa) % 2);
      chk("drv_b", int'(drv_b), 1 - ((m_idx / m_pb) % 2));
      chk("err",   int'(err_cnt), m_err);
    end
  endtask

  task automatic pulse_start(input int pa, input int pb);
    period_a = CNT_W'(pa); period_b = CNT_W'(pb);
    start = 1'b1; step(1); start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; step(2);
    rst = 1'b0; step(2);

    // ideal inverter, 100/50; periods changed after start must not matter
    pulse_start(100, 50);
    period_a = 3; period_b = 7;
    step(RUN_LEN + 4);
    chk("ideal_err_end", int'(err_cnt), 0);

    // y tied to a: every RUN cycle mismatches, count saturates
    tie_y = 1'b1;
    pulse_start(100, 50);
    step(RUN_LEN + 3);
    chk("sat_err", int'(err_cnt), ERR_MAX);
    tie_y = 1'b0;

    // zero half-period behaves as 1
    pulse_start(0, 1);
    step(RUN_LEN + 3);

    // early stop in RUN cycle 10, then restart with a 3-cycle fault
    pulse_start(4, 6);
    step(10);
    stop = 1'b1; step(1); stop = 1'b0;
    chk("stop_done", int'(done), 1);
    chk("stop_busy", int'(busy), 0);
    step(3);
    pulse_start(4, 6);
    step(20);
    flip_y = 1'b1; step(2); flip_y = 1'b0;
    flip_z = 1'b1; step(1); flip_z = 1'b0;
    step(RUN_LEN);
    chk("fault3_err", int'(err_cnt), 3);

    // start during RUN ignored, then reset mid-run
    pulse_start(5, 9);
    step(30);
    start = 1'b1; step(1); start = 1'b0;
    step(30);
    flip_z = 1'b1; step(2); flip_z = 1'b0;
    rst = 1'b1; step(1); rst = 1'b0;
    chk("rst_busy", int'(busy), 0);
    chk("rst_err", int'(err_cnt), 0);
    step(5);

    // randomized sequences
    for (int s = 0; s < 15; s++) begin
      stop = ($urandom_range(0, 3) == 0);  // ignored outside RUN
      step($urandom_range(0, 3));
      stop = 1'b0;
      pulse_start($urandom_range(0, 9), $urandom_range(0, 9));
      for (int c = 0; c < RUN_LEN + 10 && (m_busy || m_done); c++) begin
        stop   = ($urandom_range(0, 299) == 0);
        flip_y = ($urandom_range(0, 5) == 0);
        flip_z = ($urandom_range(0, 8) == 0);
        start  = ($urandom_range(0, 49) == 0);
        rst    = ($urandom_range(0, 1999) == 0);
        step(1);
      end
      stop = 1'b0; flip_y = 1'b0; flip_z = 1'b0; start = 1'b0; rst = 1'b0;
      step(2);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
